branch_target_buffer: RTL and testbench

//  Storage end of the execute stage's BTB write interface (i_wr/i_valid/w_PC/BT).

---
 rtl/branch_target_buffer_pkg.sv | 18 +
 rtl/branch_target_buffer_if.sv | 21 ++
 rtl/branch_target_buffer_flush_seq.sv | 52 +++++
 rtl/branch_target_buffer.sv | 80 ++++++++
 tb/tb_branch_target_buffer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB definitions: table geometry, row entry layout and sweep FSM states.
// Imported by the interface, the flush sequencer and the BTB top.
package definesPkg;
  localparam int BTB_num_rows = 32;
  localparam int BTB_ENTRY_W  = 18;
  localparam int IDX_W        = $clog2(BTB_num_rows);
  localparam int TAG_W        = 16 - IDX_W;
  // One extra bit so the counter can never wrap silently past the last row.
  localparam int CNT_W        = IDX_W + 1;

  typedef struct packed {
    logic        valid;
    logic        conf;
    logic [15:0] target;
  } btb_entry_t;

  typedef enum logic {BTB_IDLE, BTB_SWEEP} btb_state_t;
endpackage

// File: rtl/branch_target_buffer_if.sv
// BTB bus: fetch lookup, execute update/flush and the packed table view.
//  master: fetch/execute side (drives PCs, strobes, flush)
//  slave : BTB storage (drives hit/target, busy, BTBtable)
interface branch_target_buffer_if;
  import definesPkg::*;
  logic [15:0]                              i_rd_PC;
  logic                                     o_hit;
  logic [15:0]                              o_target;
  logic                                     i_wr;
  logic                                     i_valid;
  logic [15:0]                              w_PC;
  logic [15:0]                              i_BT;
  logic                                     i_flush;
  logic                                     o_busy;
  logic [BTB_num_rows-1:0][BTB_ENTRY_W-1:0] BTBtable;

  modport master (output i_rd_PC, i_wr, i_valid, w_PC, i_BT, i_flush,
                  input  o_hit, o_target, o_busy, BTBtable);
  modport slave  (input  i_rd_PC, i_wr, i_valid, w_PC, i_BT, i_flush,
                  output o_hit, o_target, o_busy, BTBtable);
endinterface

// File: rtl/branch_target_buffer_flush_seq.sv
// btb_flush_seq: invalidate-sweep FSM. A flush seen in IDLE starts a sweep
// that clears one row per cycle for exactly BTB_num_rows cycles.
//  clk, reset : clock, synchronous active-low reset
//  flush      : sweep request, level sampled in IDLE only
//  busy       : sweep in progress (registered state)
//  clr_en     : clear row clr_idx on this edge
//  clr_idx    : row being cleared
module btb_flush_seq
  import definesPkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic             busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx
);
  btb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BTB_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        BTB_IDLE: begin
          if (flush) begin
            state_q <= BTB_SWEEP;
            cnt_q   <= '0;
          end
        end
        BTB_SWEEP: begin
          if (cnt_q == CNT_W'(BTB_num_rows - 1)) begin
            state_q <= BTB_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= BTB_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy    = (state_q == BTB_SWEEP);
  assign clr_en  = busy;
  assign clr_idx = cnt_q[IDX_W-1:0];
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 1-bit hysteresis and flush sweep.
//  clk, reset : clock, synchronous active-low reset
//  bus        : fetch lookup (i_rd_PC -> o_hit/o_target, combinational),
//               execute update (i_wr/i_valid/w_PC/i_BT), flush (i_flush/o_busy),
//               packed registered table view BTBtable[row] = {valid,conf,target}
module branch_target_buffer
  import definesPkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  branch_target_buffer_if.slave bus
);
  btb_entry_t [BTB_num_rows-1:0]             rows_q, rows_d;
  logic       [BTB_num_rows-1:0][TAG_W-1:0]  tags_q, tags_d;

  logic             busy, clr_en;
  logic [IDX_W-1:0] clr_idx;

  btb_flush_seq u_flush_seq (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.i_flush),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [TAG_W-1:0] wr_tag, rd_tag;
  logic             wr_match, wr_en;

  assign wr_idx   = bus.w_PC[IDX_W-1:0];
  assign wr_tag   = bus.w_PC[15:IDX_W];
  assign wr_match = rows_q[wr_idx].valid && (tags_q[wr_idx] == wr_tag);
  // A flush raised in IDLE wins over a same-cycle update; updates are ignored while sweeping.
  assign wr_en    = bus.i_wr && !busy && !bus.i_flush;

  always_comb begin
    rows_d = rows_q;
    tags_d = tags_q;
    if (clr_en) begin
      // Sweep clears valid/conf/target; stale tags are harmless once valid is 0.
      rows_d[clr_idx] = '0;
    end else if (wr_en) begin
      if (bus.i_valid) begin
        if (wr_match) begin
          rows_d[wr_idx].target = bus.i_BT;
          rows_d[wr_idx].conf   = 1'b1;
        end else begin
          rows_d[wr_idx].valid  = 1'b1;
          rows_d[wr_idx].conf   = 1'b0;
          rows_d[wr_idx].target = bus.i_BT;
          tags_d[wr_idx]        = wr_tag;
        end
      end else if (wr_match) begin
        // Hysteresis: a confident entry survives one mispredict.
        if (rows_q[wr_idx].conf) rows_d[wr_idx].conf  = 1'b0;
        else                     rows_d[wr_idx].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_q <= '0;
      tags_q <= '0;
    end else begin
      rows_q <= rows_d;
      tags_q <= tags_d;
    end
  end

  // Lookup sees registered state only; no bypass of an in-flight write.
  assign rd_idx       = bus.i_rd_PC[IDX_W-1:0];
  assign rd_tag       = bus.i_rd_PC[15:IDX_W];
  assign bus.o_hit    = !busy && rows_q[rd_idx].valid && (tags_q[rd_idx] == rd_tag);
  assign bus.o_target = bus.o_hit ? rows_q[rd_idx].target : 16'h0;
  assign bus.o_busy   = busy;
  assign bus.BTBtable = rows_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
  import definesPkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_target_buffer_if bif();
  branch_target_buffer dut (.clk(clk), .reset(reset), .bus(bif));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain per-row arrays plus "sweep cycles remaining".
  bit          m_valid [BTB_num_rows];
  bit          m_conf  [BTB_num_rows];
  logic [15:0] m_tgt   [BTB_num_rows];
  int          m_tag   [BTB_num_rows];
  int          m_sweep_left = 0;
  int          m_pos = 0;

  task automatic model_edge();
    int idx, tag;
    bit match;
    if (!reset) begin
      for (int r = 0; r < BTB_num_rows; r++) begin
        m_valid[r] = 0; m_conf[r] = 0; m_tgt[r] = 16'h0; m_tag[r] = 0;
      end
      m_sweep_left = 0;
      m_pos = 0;
    end else if (m_sweep_left > 0) begin
      m_valid[m_pos] = 0; m_conf[m_pos] = 0; m_tgt[m_pos] = 16'h0;
      m_pos++;
      m_sweep_left--;
    end else if (bif.i_flush) begin
      m_sweep_left = BTB_num_rows;
      m_pos = 0;
    end else if (bif.i_wr) begin
      idx = int'(bif.w_PC) % BTB_num_rows;
      tag = int'(bif.w_PC) / BTB_num_rows;
      match = m_valid[idx] && (m_tag[idx] == tag);
      if (bif.i_valid) begin
        if (match) begin
          m_tgt[idx] = bif.i_BT; m_conf[idx] = 1;
        end else begin
          m_valid[idx] = 1; m_conf[idx] = 0; m_tag[idx] = tag; m_tgt[idx] = bif.i_BT;
        end
      end else if (match) begin
        if (m_conf[idx]) m_conf[idx] = 0;
        else             m_valid[idx] = 0;
      end
    end
  endtask

  function automatic logic [BTB_num_rows-1:0][17:0] exp_table();
    logic [BTB_num_rows-1:0][17:0] t;
    for (int r = 0; r < BTB_num_rows; r++) t[r] = {m_valid[r], m_conf[r], m_tgt[r]};
    return t;
  endfunction

  function automatic logic exp_hit(input logic [15:0] pc);
    int idx;
    idx = int'(pc) % BTB_num_rows;
    return (m_sweep_left == 0) && m_valid[idx] && (m_tag[idx] == int'(pc) / BTB_num_rows);
  endfunction

  function automatic logic [15:0] exp_target(input logic [15:0] pc);
    return exp_hit(pc) ? m_tgt[int'(pc) % BTB_num_rows] : 16'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bif.i_wr = 0; bif.i_valid = 0; bif.w_PC = 16'h0; bif.i_BT = 16'h0; bif.i_flush = 0;
  endtask

  task automatic do_write(input logic [15:0] pc, input logic [15:0] bt, input logic v);
    bif.i_wr = 1; bif.i_valid = v; bif.w_PC = pc; bif.i_BT = bt;
    tick();
    bif.i_wr = 0;
  endtask

  task automatic test_reset();
    do_write(16'h0042, 16'h1234, 1);
    do_write(16'h0107, 16'h5678, 1);
    bif.i_rd_PC = 16'h0042;
    reset = 0;
    tick(); tick();
    reset = 1;
    #1;
    vectors++;
    if (bif.BTBtable !== '0) begin
      miscompares++; $display("FAIL reset_table got %h want 0", bif.BTBtable);
    end
    vectors++;
    if (bif.o_hit !== 1'b0 || bif.o_target !== 16'h0) begin
      miscompares++; $display("FAIL reset_hit got %b/%h want 0/0000", bif.o_hit, bif.o_target);
    end
    vectors++;
    if (bif.o_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", bif.o_busy);
    end
  endtask

  task automatic test_alloc();
    bif.i_wr = 1; bif.i_valid = 1; bif.w_PC = 16'h0042; bif.i_BT = 16'h0100;
    bif.i_rd_PC = 16'h0042;
    #1;
    vectors++;
    if (bif.o_hit !== 1'b0) begin
      miscompares++; $display("FAIL alloc_same_cycle got hit=%b want 0", bif.o_hit);
    end
    tick();
    bif.i_wr = 0;
    #1;
    vectors++;
    if (bif.BTBtable[2] !== 18'h20100) begin
      miscompares++; $display("FAIL alloc_row got %h want 20100", bif.BTBtable[2]);
    end
    vectors++;
    if (bif.o_hit !== 1'b1 || bif.o_target !== 16'h0100) begin
      miscompares++; $display("FAIL alloc_lookup got %b/%h want 1/0100", bif.o_hit, bif.o_target);
    end
  endtask

  task automatic test_replace();
    do_write(16'h0062, 16'h0200, 1);
    bif.i_rd_PC = 16'h0042;
    #1;
    vectors++;
    if (bif.o_hit !== 1'b0) begin
      miscompares++; $display("FAIL replace_old got hit=%b want 0", bif.o_hit);
    end
    bif.i_rd_PC = 16'h0062;
    #1;
    vectors++;
    if (bif.o_hit !== 1'b1 || bif.o_target !== 16'h0200) begin
      miscompares++; $display("FAIL replace_new got %b/%h want 1/0200", bif.o_hit, bif.o_target);
    end
  endtask

  task automatic test_hysteresis();
    do_write(16'h0042, 16'h0100, 1);
    do_write(16'h0042, 16'h0100, 1);
    bif.i_rd_PC = 16'h0042;
    #1;
    vectors++;
    if (bif.BTBtable[2] !== 18'h30100 || bif.o_hit !== 1'b1) begin
      miscompares++; $display("FAIL hyst_train got %h hit=%b want 30100 hit=1", bif.BTBtable[2], bif.o_hit);
    end
    do_write(16'h0042, 16'h0000, 0);
    #1;
    vectors++;
    if (bif.BTBtable[2] !== 18'h20100 || bif.o_hit !== 1'b1 || bif.o_target !== 16'h0100) begin
      miscompares++; $display("FAIL hyst_weaken got %h hit=%b tgt=%h want 20100 1 0100",
                              bif.BTBtable[2], bif.o_hit, bif.o_target);
    end
    do_write(16'h0042, 16'h0000, 0);
    #1;
    vectors++;
    if (bif.BTBtable[2][17] !== 1'b0 || bif.o_hit !== 1'b0) begin
      miscompares++; $display("FAIL hyst_evict got %h hit=%b want valid=0 hit=0", bif.BTBtable[2], bif.o_hit);
    end
    do_write(16'h0062, 16'h0000, 0);
    #1;
    vectors++;
    if (bif.BTBtable[2] !== 18'h00100) begin
      miscompares++; $display("FAIL hyst_nomatch got %h want 00100", bif.BTBtable[2]);
    end
  endtask

  task automatic test_flush();
    logic [15:0] fill_pc [BTB_num_rows];
    int busy_cycles = 0;
    for (int r = 0; r < BTB_num_rows; r++) begin
      fill_pc[r] = 16'(($urandom % 2048) * BTB_num_rows + r);
      do_write(fill_pc[r], 16'($urandom), 1);
    end
    bif.i_rd_PC = fill_pc[7];
    bif.i_flush = 1;
    #1;
    vectors++;
    if (bif.o_hit !== 1'b1) begin
      miscompares++; $display("FAIL flush_prehit got %b want 1", bif.o_hit);
    end
    tick();
    bif.i_flush = 0;
    for (int cyc = 0; cyc < 3 * BTB_num_rows; cyc++) begin
      idle_inputs();
      if (cyc == 5) begin
        bif.i_wr = 1; bif.i_valid = 1; bif.w_PC = fill_pc[3]; bif.i_BT = 16'hBEEF;
      end
      if (cyc == 8) bif.i_flush = 1;
      bif.i_rd_PC = fill_pc[(cyc + 20) % BTB_num_rows];
      #1;
      if (bif.o_busy !== 1'b1) break;
      busy_cycles++;
      vectors++;
      if (bif.o_hit !== 1'b0 || bif.o_hit !== exp_hit(bif.i_rd_PC)) begin
        miscompares++; $display("FAIL flush_hit cyc %0d got %b want 0", cyc, bif.o_hit);
      end
      tick();
    end
    idle_inputs();
    vectors++;
    if (busy_cycles != BTB_num_rows) begin
      miscompares++; $display("FAIL flush_len got %0d want %0d", busy_cycles, BTB_num_rows);
    end
    vectors++;
    if (bif.BTBtable !== '0 || bif.BTBtable !== exp_table()) begin
      miscompares++; $display("FAIL flush_table got %h want 0", bif.BTBtable);
    end
  endtask

  task automatic test_reset_sweep();
    for (int r = 0; r < 16; r++) do_write(16'(r + 32 * ($urandom % 8)), 16'($urandom), 1);
    bif.i_flush = 1;
    tick();
    bif.i_flush = 0;
    for (int c = 0; c < 10; c++) tick();
    reset = 0;
    tick();
    reset = 1;
    #1;
    vectors++;
    if (bif.o_busy !== 1'b0 || bif.BTBtable !== '0) begin
      miscompares++; $display("FAIL rst_sweep got busy=%b tbl=%h want 0/0", bif.o_busy, bif.BTBtable);
    end
    do_write(16'h0042, 16'h0100, 1);
    bif.i_rd_PC = 16'h0042;
    #1;
    vectors++;
    if (bif.o_hit !== 1'b1 || bif.o_target !== 16'h0100 || bif.BTBtable[2] !== 18'h20100) begin
      miscompares++; $display("FAIL rst_sweep_alloc got %b/%h/%h want 1/0100/20100",
                              bif.o_hit, bif.o_target, bif.BTBtable[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bif.i_wr    = ($urandom % 3) != 0;
      bif.i_valid = ($urandom % 3) != 0;
      bif.w_PC    = 16'(($urandom % 3) * BTB_num_rows + ($urandom % 8));
      bif.i_BT    = 16'($urandom);
      bif.i_flush = ($urandom % 80) == 0;
      reset       = ($urandom % 200) != 0;
      bif.i_rd_PC = 16'(($urandom % 3) * BTB_num_rows + ($urandom % 8));
      #1;
      vectors++;
      if (bif.o_busy !== (m_sweep_left > 0) || bif.o_hit !== exp_hit(bif.i_rd_PC) ||
          bif.o_target !== exp_target(bif.i_rd_PC)) begin
        miscompares++;
        $display("FAIL rand_lookup it %0d pc %h got busy=%b hit=%b tgt=%h want %b/%b/%h", i, bif.i_rd_PC,
                 bif.o_busy, bif.o_hit, bif.o_target, m_sweep_left > 0, exp_hit(bif.i_rd_PC),
                 exp_target(bif.i_rd_PC));
      end
      vectors++;
      if (bif.BTBtable !== exp_table()) begin
        miscompares++; $display("FAIL rand_table it %0d got %h want %h", i, bif.BTBtable, exp_table());
      end
      tick();
    end
    reset = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bif.i_rd_PC = 16'h0;
    reset = 0;
    tick(); tick();
    reset = 1;
    test_reset();
    test_alloc();
    test_replace();
    test_hysteresis();
    test_flush();
    test_reset_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
